// File: rtl/fft_frame_sequencer.sv
// -----------------------------------------------------------------------------
// fft_frame_sequencer
//
// Bring-up sequencer for FFT_top. On start it plays one N-point frame of test
// stimulus into the FFT, idles for a fixed pipeline delay, then stores the N
// FFT output samples in an internal RAM. The host reads that RAM back by
// address once the frame is done.
//
// Optional build macro:
//   FFT_SEQ_PEAK_SEARCH_EN  track the largest |X|^2 bin during capture. When it
//                           is undefined, peak_bin and peak_pow are tied to 0.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   start                one-cycle frame request, accepted only in IDLE
//   mode, const_val      stimulus select and amplitude, latched at start
//   ext_re, ext_im       external stimulus, sampled every FEED cycle
//   fft_enable           enable to FFT_top, high for the N FEED samples
//   xb_re, xb_im         stimulus to FFT_top
//   Xb_re, Xb_im         FFT_top outputs, captured without a valid qualifier
//   busy, done           busy from FEED through CAPTURE; done is a 1-cycle pulse
//   rd_addr              readback address
//   rd_re, rd_im         readback data, 1-cycle latency, zero while busy
//   peak_bin, peak_pow   peak bin index and power (optional feature)
// -----------------------------------------------------------------------------
module fft_frame_sequencer #(
    parameter int DATA_W        = 16,
    parameter int LOG2_N        = 10,
    parameter int CAPTURE_DELAY = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic signed [DATA_W-1:0]   const_val,
    input  logic signed [DATA_W-1:0]   ext_re,
    input  logic signed [DATA_W-1:0]   ext_im,
    output logic                       fft_enable,
    output logic signed [DATA_W-1:0]   xb_re,
    output logic signed [DATA_W-1:0]   xb_im,
    input  logic signed [DATA_W-1:0]   Xb_re,
    input  logic signed [DATA_W-1:0]   Xb_im,
    output logic                       busy,
    output logic                       done,
    input  logic [LOG2_N-1:0]          rd_addr,
    output logic signed [DATA_W-1:0]   rd_re,
    output logic signed [DATA_W-1:0]   rd_im,
    output logic [LOG2_N-1:0]          peak_bin,
    output logic [2*DATA_W-1:0]        peak_pow
);

    localparam int N      = 1 << LOG2_N;
    localparam int WAIT_W = (CAPTURE_DELAY > 1) ? $clog2(CAPTURE_DELAY) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FEED, S_WAIT, S_CAPTURE, S_DONE} state_t;
    typedef enum logic [1:0] {M_CONST, M_IMPULSE, M_RAMP, M_EXT} mode_t;

    state_t                    r_state;
    mode_t                     r_mode;
    logic signed [DATA_W-1:0]  r_const;
    logic [LOG2_N-1:0]         r_cnt;    // sample index in FEED and CAPTURE
    logic [WAIT_W-1:0]         r_wait;

    logic signed [DATA_W-1:0]  r_ram_re [N];
    logic signed [DATA_W-1:0]  r_ram_im [N];

    logic signed [DATA_W-1:0]  w_stim_re;
    logic signed [DATA_W-1:0]  w_stim_im;
    logic                      w_accept;
    logic                      w_busy_next;

    // A start arriving while the done pulse is still high is dropped, so a
    // request can only be taken from the first IDLE cycle after the pulse.
    assign w_accept    = (r_state == S_IDLE) && start && !done;
    assign w_busy_next = (r_state == S_FEED) || (r_state == S_WAIT) || (r_state == S_CAPTURE);

    // NOTE: every output of an always_comb gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        w_stim_re = '0;
        w_stim_im = '0;
        case (r_mode)
            M_CONST:   w_stim_re = r_const;
            M_IMPULSE: if (r_cnt == '0) w_stim_re = r_const;
            M_RAMP:    w_stim_re = DATA_W'(r_cnt);   // wraps modulo 2**DATA_W
            M_EXT: begin
                w_stim_re = ext_re;
                w_stim_im = ext_im;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // sees the pre-edge value of every other flop regardless of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_mode     <= M_CONST;
            r_const    <= '0;
            r_cnt      <= '0;
            r_wait     <= '0;
            fft_enable <= 1'b0;
            xb_re      <= '0;
            xb_im      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mode  <= mode_t'(mode);
                        r_const <= const_val;
                        r_cnt   <= '0;
                        r_state <= S_FEED;
                    end
                end
                S_FEED: begin
                    fft_enable <= 1'b1;
                    busy       <= 1'b1;
                    xb_re      <= w_stim_re;
                    xb_im      <= w_stim_im;
                    r_cnt      <= r_cnt + 1'b1;   // wraps to 0 after the last sample
                    if (r_cnt == '1) begin
                        r_wait  <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    fft_enable <= 1'b0;
                    xb_re      <= '0;
                    xb_im      <= '0;
                    if (r_wait == WAIT_W'(CAPTURE_DELAY - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_CAPTURE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '1) r_state <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the capture RAM has no reset; its contents are only meaningful
    // after a completed frame, and leaving it unreset lets it map to block RAM.
    always_ff @(posedge clk) begin
        if (r_state == S_CAPTURE) begin
            r_ram_re[r_cnt] <= Xb_re;
            r_ram_im[r_cnt] <= Xb_im;
        end
    end

    // Blanking looks at the state being left at this edge, so the read
    // register is already zero in the first busy cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_re <= '0;
            rd_im <= '0;
        end else if (w_busy_next) begin
            rd_re <= '0;
            rd_im <= '0;
        end else begin
            rd_re <= r_ram_re[rd_addr];
            rd_im <= r_ram_im[rd_addr];
        end
    end

`ifdef FFT_SEQ_PEAK_SEARCH_EN
    localparam int P_W = 2 * DATA_W;

    logic signed [P_W-1:0] w_sq_re;
    logic signed [P_W-1:0] w_sq_im;
    logic [P_W-1:0]        w_pow;

    // Each square is non-negative and at most 2**(2*DATA_W-2), so the
    // unsigned sum cannot overflow P_W bits.
    assign w_sq_re = P_W'(Xb_re) * P_W'(Xb_re);
    assign w_sq_im = P_W'(Xb_im) * P_W'(Xb_im);
    assign w_pow   = $unsigned(w_sq_re) + $unsigned(w_sq_im);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_bin <= '0;
            peak_pow <= '0;
        end else if (w_accept) begin
            peak_bin <= '0;
            peak_pow <= '0;
        end else if (r_state == S_CAPTURE && w_pow > peak_pow) begin
            // Strict compare: the lowest bin wins ties.
            peak_bin <= r_cnt;
            peak_pow <= w_pow;
        end
    end
`else
    assign peak_bin = '0;
    assign peak_pow = '0;
`endif

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Synthesizable frame sequencer for on-board FFT_top bring-up.
- On `start`, drives one N-point frame of test stimulus into FFT_top and waits a fixed pipeline delay.
- Then captures N output samples into an internal dual-field RAM, which the host reads back by address.
- Generalises frame length, sample width, capture delay and stimulus pattern. Sits between the control/host interface and FFT_top.

Parameters:
- DATA_W, 16: signed sample width of re/im on both stimulus and capture paths.
- LOG2_N, 10: log2 of frame length; N = 2**LOG2_N.
- CAPTURE_DELAY, 10: idle cycles between the last stimulus sample and the first captured sample; minimum 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  2  stimulus select, latched at start: 0 constant, 1 impulse, 2 ramp, 3 external.
- const_val  in  DATA_W  signed amplitude for modes 0/1, latched at start.
- ext_re, ext_im  in  DATA_W each  external stimulus (mode 3); sampled every FEED cycle.
- fft_enable  out  1  to FFT_top enable.
- xb_re, xb_im  out  DATA_W each  stimulus to FFT_top.
- Xb_re, Xb_im  in  DATA_W each  FFT_top outputs.
- busy  out  1  high from FEED through CAPTURE.
- done  out  1  one-cycle pulse when the frame is stored.
- rd_addr  in  LOG2_N  readback address.
- rd_re, rd_im  out  DATA_W each  readback data.
- peak_bin  out  LOG2_N  see Optional Feature.
- peak_pow  out  2*DATA_W  unsigned; see Optional Feature.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters 0. RAM contents are not cleared.
- Reset mid-operation aborts the frame immediately; no `done` pulse is produced.
- FSM states: IDLE -> FEED -> WAIT -> CAPTURE -> DONE -> IDLE.
- IDLE:
  - `start`=1 at edge E latches `mode` and `const_val` and enters FEED.
  - `start` in any other state is ignored; no queuing.
- FEED (N cycles):
  - `fft_enable`=1 and sample k (k=0..N-1) is registered onto `xb_re`/`xb_im` at edge E+1+k.
  - Stimulus by mode:
    - constant: re=const_val, im=0.
    - impulse: re=const_val at k=0, else 0; im=0.
    - ramp: re=k truncated to DATA_W bits (wraps modulo 2**DATA_W, two's complement), im=0.
    - external: ext_re/ext_im sampled at edge E+1+k.
  - At edge E+1+N: `fft_enable`=0, `xb_re`/`xb_im`=0, enter WAIT.
- WAIT: count CAPTURE_DELAY cycles, then enter CAPTURE.
- CAPTURE (N cycles):
  - `Xb_re`/`Xb_im` are sampled at edge E+1+N+CAPTURE_DELAY+j and written to RAM[j], for j=0..N-1.
  - Sampling is unconditional; there is no valid from FFT_top.
- DONE:
  - One cycle.
  - `done`=1 on the edge after the last write; `busy` falls on the same edge.
  - FSM returns to IDLE next cycle.
- `busy`=1 from edge E+1 until the DONE edge.
- Readback:
  - `rd_re`/`rd_im` are registered with 1-cycle latency from `rd_addr`.
  - While `busy`=1 they are forced to 0.
  - Back-to-back addresses are supported every cycle.
- `start` asserted in the same cycle as the DONE pulse is ignored; it is accepted from the following IDLE cycle.

Optional Feature:
- Macro: FFT_SEQ_PEAK_SEARCH_EN.
- Defined:
  - During CAPTURE, compute p = Xb_re^2 + Xb_im^2 (signed squares, unsigned 2*DATA_W sum, no overflow: max 2^31 at DATA_W=16).
  - Track maximum with strict greater-than, so the lowest index wins ties.
  - Tracker clears to bin 0 / pow 0 on entry to FEED.
  - `peak_bin`/`peak_pow` are updated by the DONE edge, then held until the next start or reset.
- Not defined: `peak_bin` and `peak_pow` are tied to 0; no multipliers are instantiated.

Test Plan:
- Bench setup:
  - LOG2_N=4, CAPTURE_DELAY=2.
  - FFT stub is a pure delay line of N+CAPTURE_DELAY=18 cycles from xb to Xb, enable-independent.
- Mode 0, const_val=1 -> `fft_enable` high exactly 16 cycles; RAM[0..15] all re=1, im=0; `done` pulses once, 1+16+2+16 cycles after start.
- Mode 2 ramp -> RAM[j] re=j for j=0..15. Repeat with DATA_W=4: RAM[8] re reads -8 (wrap).
- Mode 1, const_val=-5 -> RAM[0]=-5, RAM[1..15]=0. With FFT_SEQ_PEAK_SEARCH_EN: peak_bin=0, peak_pow=25.
- Mode 3, ext_re=3*k, ext_im=-k -> RAM[j]=(3j,-j). With the macro: peak_bin=15, peak_pow=2250. Readback at consecutive addresses returns data 1 cycle later; reads while busy return 0.
- Second `start` pulsed during WAIT and during DONE -> ignored; exactly one `done` pulse.
- `rst`=0 mid-CAPTURE -> all outputs 0 and FSM in IDLE. A new start then completes normally with correct data.
